// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Shares the single write port and single read port of a 4x8 register
//   file between two requesters. One operation (read or write) is issued
//   per cycle. Fair round-robin between the two requesters, with an
//   optional lock that lets one requester keep the file for a bounded burst
//   of up to MAX_BURST consecutive grants.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid[i]      requester i has an operation pending
//   req_we[i]         1 = write, 0 = read
//   req_lock[i]       requester i wants to keep the grant after this transfer
//   req_addr/wdata    requester i fields at [i*W +: W]
//   req_ready[i]      requester i accepted this cycle (one-hot or zero)
//   rsp_valid[i]      1-cycle pulse, rsp_rdata holds requester i's read data
//   gnt_id            index of the last granted requester
//   locked            lock state register (LOCKED = 1)
//   rf_*              direct drive of the register file ports; rf_r_data is
//                     the file's combinational read data
//
// Handshake: a transfer happens on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready depends combinationally on req_valid
// and internal state only, never on the cycle's other data inputs. There is
// no backpressure on responses: rsp_valid is a single-cycle pulse.
module reg_file_arbiter #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  gnt_id,
  output logic                  locked,
  output logic                  rf_wr_en,
  output logic [ADDR_W-1:0]     rf_w_addr,
  output logic [DATA_W-1:0]     rf_w_data,
  output logic [ADDR_W-1:0]     rf_r_addr,
  input  logic [DATA_W-1:0]     rf_r_data
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
  // A burst of one grant is no lock at all, so req_lock is ignored then.
  localparam logic              LOCK_EN   = (MAX_BURST > 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic              w_prio_nxt;
  logic              r_lock_owner;
  logic              w_owner_nxt;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_gnt_id;

  logic              w_owner_active;
  logic              w_grant;
  logic              w_gnt_idx;
  logic              w_gnt_we;
  logic              w_keep;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;

  // Arbitration. A lock only binds while its owner is still requesting;
  // when the owner goes idle the same cycle falls through to the ordinary
  // round-robin choice, so the other requester loses no cycle. Nothing is
  // granted while reset is asserted, which also keeps rf_wr_en low.
  always_comb begin
    w_owner_active = (r_state == ST_LOCKED) && req_valid[r_lock_owner];
    w_grant        = 1'b0;
    w_gnt_idx      = 1'b0;
    if (rst_n) begin
      if (w_owner_active) begin
        w_grant   = 1'b1;
        w_gnt_idx = r_lock_owner;
      end else if (&req_valid) begin
        w_grant   = 1'b1;
        w_gnt_idx = r_prio;
      end else if (req_valid[0]) begin
        w_grant   = 1'b1;
        w_gnt_idx = 1'b0;
      end else if (req_valid[1]) begin
        w_grant   = 1'b1;
        w_gnt_idx = 1'b1;
      end
    end
  end

  // Steer the granted requester's fields onto the register file ports;
  // unused ports are held at zero.
  always_comb begin
    w_addr_sel  = w_gnt_idx ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    w_wdata_sel = w_gnt_idx ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    w_gnt_we    = req_we[w_gnt_idx];
    req_ready   = 2'b00;
    rf_wr_en    = 1'b0;
    rf_w_addr   = '0;
    rf_w_data   = '0;
    rf_r_addr   = '0;
    if (w_grant) begin
      req_ready[w_gnt_idx] = 1'b1;
      if (w_gnt_we) begin
        rf_wr_en  = 1'b1;
        rf_w_addr = w_addr_sel;
        rf_w_data = w_wdata_sel;
      end else begin
        rf_r_addr = w_addr_sel;
      end
    end
  end

  // Lock/burst next state. The burst count is the number of grants already
  // given inside the current lock; the grant that would reach MAX_BURST
  // ends the lock and hands priority to the other requester.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_owner_nxt = r_lock_owner;
    w_cnt_nxt   = r_burst_cnt;
    w_cnt_inc   = r_burst_cnt + CNT_W'(1);
    w_keep      = LOCK_EN && req_lock[w_gnt_idx] &&
                  (!w_owner_active || (w_cnt_inc < BURST_MAX));
    if (w_grant) begin
      if (w_keep) begin
        w_state_nxt = ST_LOCKED;
        if (w_owner_active) begin
          w_cnt_nxt = w_cnt_inc;
        end else begin
          w_owner_nxt = w_gnt_idx;
          w_cnt_nxt   = CNT_W'(1);
        end
      end else begin
        w_state_nxt = ST_UNLOCKED;
        w_cnt_nxt   = '0;
        w_prio_nxt  = ~w_gnt_idx;
      end
    end else if (r_state == ST_LOCKED) begin
      w_state_nxt = ST_UNLOCKED;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNLOCKED;
      r_prio       <= 1'b0;
      r_lock_owner <= 1'b0;
      r_burst_cnt  <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= '0;
      r_gnt_id     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prio       <= w_prio_nxt;
      r_lock_owner <= w_owner_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      // On a read grant req_ready is exactly the one-hot response target.
      r_rsp_valid  <= w_gnt_we ? 2'b00 : req_ready;
      if (w_grant) begin
        r_gnt_id <= w_gnt_idx;
      end
      if (w_grant && !w_gnt_we) begin
        r_rsp_rdata <= rf_r_data;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign gnt_id    = r_gnt_id;
  assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Testbench for reg_file_arbiter: directed table of the key scenarios, an
// asynchronous reset in the middle of a locked read, then random traffic
// checked against a rule-level model of the arbiter and a register file.
module tb_reg_file_arbiter;

  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_we;
  logic [1:0]           req_lock;
  logic [2*ADDR_W-1:0]  req_addr;
  logic [2*DATA_W-1:0]  req_wdata;
  logic [1:0]           req_ready;
  logic [1:0]           rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 gnt_id;
  logic                 locked;
  logic                 rf_wr_en;
  logic [ADDR_W-1:0]    rf_w_addr;
  logic [DATA_W-1:0]    rf_w_data;
  logic [ADDR_W-1:0]    rf_r_addr;
  logic [DATA_W-1:0]    rf_r_data;

  reg_file_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .gnt_id(gnt_id), .locked(locked),
    .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data)
  );

  // Register file driven by the DUT: write on the edge, combinational read.
  logic [7:0] rf_mem [4] = '{default: 8'd0};
  always @(posedge clk) if (rf_wr_en) rf_mem[rf_w_addr] <= rf_w_data;
  assign rf_r_data = rf_mem[rf_r_addr];

  // ---------------- reference model ----------------
  bit         m_locked;
  bit         m_owner;
  int         m_cnt;
  bit         m_prio;
  bit         m_gnt_id;
  logic [1:0] m_rsp_valid;
  logic [7:0] m_last_rdata;
  logic [7:0] m_mem [4] = '{default: 8'd0};
  logic [7:0] exp_q [$];
  bit         p_g;
  bit         p_gi;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_cnt = 0; m_prio = 0; m_gnt_id = 0;
    m_rsp_valid = 2'b00; m_last_rdata = 8'd0;
    exp_q.delete();
  endtask

  // Who gets the port this cycle, from the arbitration rules.
  task automatic predict();
    bit owner_active;
    owner_active = m_locked && req_valid[m_owner];
    p_g = 0; p_gi = 0;
    if (owner_active)            begin p_g = 1; p_gi = m_owner; end
    else if (req_valid == 2'b11) begin p_g = 1; p_gi = m_prio;  end
    else if (req_valid[0])       begin p_g = 1; p_gi = 0;       end
    else if (req_valid[1])       begin p_g = 1; p_gi = 1;       end
  endtask

  // Advance the model by one accepted edge.
  task automatic commit();
    bit owner_active;
    bit keep;
    int a;
    owner_active = m_locked && req_valid[m_owner];
    m_rsp_valid = 2'b00;
    if (p_g) begin
      a = int'(req_addr[int'(p_gi)*2 +: 2]);
      m_gnt_id = p_gi;
      if (req_we[p_gi]) m_mem[a] = req_wdata[int'(p_gi)*8 +: 8];
      else begin
        m_rsp_valid = p_gi ? 2'b10 : 2'b01;
        exp_q.push_back(m_mem[a]);
      end
      keep = req_lock[p_gi] && (MAX_BURST > 1) && (!owner_active || (m_cnt + 1 < MAX_BURST));
      if (keep) begin
        if (owner_active) m_cnt = m_cnt + 1;
        else begin m_owner = p_gi; m_cnt = 1; end
        m_locked = 1;
      end else begin
        m_locked = 0; m_cnt = 0; m_prio = !p_gi;
      end
    end else if (m_locked) begin
      m_locked = 0; m_cnt = 0;
    end
  endtask

  task automatic check_all();
    logic [1:0] er;
    logic       ewr;
    logic       erd;
    logic [1:0] ea;
    logic [7:0] ed;
    predict();
    er  = p_g ? (p_gi ? 2'b10 : 2'b01) : 2'b00;
    ewr = p_g && req_we[p_gi];
    erd = p_g && !req_we[p_gi];
    ea  = req_addr[int'(p_gi)*2 +: 2];
    ed  = req_wdata[int'(p_gi)*8 +: 8];
    chk("req_ready", 16'(req_ready), 16'(er));
    chk("rf_wr_en",  16'(rf_wr_en),  16'(ewr));
    chk("rf_w_addr", 16'(rf_w_addr), ewr ? 16'(ea) : 16'd0);
    chk("rf_w_data", 16'(rf_w_data), ewr ? 16'(ed) : 16'd0);
    chk("rf_r_addr", 16'(rf_r_addr), erd ? 16'(ea) : 16'd0);
    chk("rsp_valid", 16'(rsp_valid), 16'(m_rsp_valid));
    if (m_rsp_valid != 2'b00 && exp_q.size() > 0) m_last_rdata = exp_q.pop_front();
    chk("rsp_rdata", 16'(rsp_rdata), 16'(m_last_rdata));
    chk("gnt_id",    16'(gnt_id),    16'(m_gnt_id));
    chk("locked",    16'(locked),    16'(m_locked));
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [3:0] a, input logic [15:0] wd);
    @(negedge clk);
    req_valid = v; req_we = we; req_lock = lk; req_addr = a; req_wdata = wd;
    #1;
    check_all();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [1:0]  lk;
    logic [3:0]  addr;   // {addr1, addr0}
    logic [15:0] wd;     // {wdata1, wdata0}
    logic [1:0]  exp_ready;
    logic        exp_wr;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                     input logic [3:0] a, input logic [15:0] wd,
                     input logic [1:0] rdy, input logic wr);
    vec_t e;
    e.v = v; e.we = we; e.lk = lk; e.addr = a; e.wd = wd; e.exp_ready = rdy; e.exp_wr = wr;
    tbl.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00; req_addr = '0; req_wdata = '0;
    model_reset();

    // preload and single write/read: addr0=100, addr1=101, addr2=110, read addr2
    add(2'b01, 2'b01, 2'b00, 4'h0, 16'd100, 2'b01, 1'b1);
    add(2'b01, 2'b01, 2'b00, 4'h1, 16'd101, 2'b01, 1'b1);
    add(2'b01, 2'b01, 2'b00, 4'h2, 16'd110, 2'b01, 1'b1);
    add(2'b01, 2'b00, 2'b00, 4'h2, 16'd0,   2'b01, 1'b0);
    // requester 1 read hands priority back to requester 0
    add(2'b10, 2'b00, 2'b00, 4'h8, 16'd0,   2'b10, 1'b0);
    // contention: req0 reads addr0, req1 reads addr1 -> 0,1,0,1
    for (int i = 0; i < 4; i++) add(2'b11, 2'b00, 2'b00, 4'h4, 16'd0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
    // req0 alone, so priority points at req1 for the burst
    add(2'b01, 2'b00, 2'b00, 4'h0, 16'd0,   2'b01, 1'b0);
    // locked burst of 4 writes of 120 to addr3 by req1, then forced release
    for (int i = 0; i < 4; i++) add(2'b11, 2'b10, 2'b10, 4'hC, {8'd120, 8'd0}, 2'b10, 1'b1);
    add(2'b11, 2'b10, 2'b10, 4'hC, {8'd120, 8'd0}, 2'b01, 1'b0);
    // lock entry by req1, then owner drops valid: req0 granted same cycle
    add(2'b10, 2'b10, 2'b10, 4'hC, {8'd120, 8'd0}, 2'b10, 1'b1);
    add(2'b01, 2'b00, 2'b00, 4'h3, 16'd0,   2'b01, 1'b0);
    // idle
    for (int i = 0; i < 5; i++) add(2'b00, 2'b00, 2'b00, 4'h0, 16'd0, 2'b00, 1'b0);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].addr, tbl[i].wd);
      chk("tbl_ready", 16'(req_ready), 16'(tbl[i].exp_ready));
      chk("tbl_wr_en", 16'(rf_wr_en),  16'(tbl[i].exp_wr));
      commit();
    end

    // asynchronous reset between a locked read's accept and its response edge
    apply(2'b10, 2'b10, 2'b10, 4'h4, 16'h3700);
    commit();
    apply(2'b10, 2'b00, 2'b10, 4'h4, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_locked",    16'(locked),    16'd0);
    chk("rst_ready",     16'(req_ready), 16'd0);
    chk("rst_wr_en",     16'(rf_wr_en),  16'd0);
    chk("rst_gnt_id",    16'(gnt_id),    16'd0);
    req_valid = 2'b11; req_we = 2'b11;
    #1;
    chk("rst_wr_gate",   16'(rf_wr_en),  16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
    apply(2'b11, 2'b00, 2'b00, 4'h4, 16'd0);
    chk("prio_after_reset", 16'(req_ready), 16'd1);
    commit();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      apply(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 16'($urandom));
      commit();
    end
    apply(2'b00, 2'b00, 2'b00, 4'h0, 16'd0);
    commit();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
Round-robin arbiter that shares the single write port and single read port of the 4x8 register file between two requesters. Each requester uses a valid/ready handshake. Only one operation, a read or a write, is issued per cycle. An optional lock lets a requester hold the register file for a bounded burst. The block sits between two client masters and the register file instance, and drives the file's wr_en, w_addr, w_data and r_addr directly.

Parameters:
ADDR_W, 2, register file address width (4 entries)
DATA_W, 8, register file data width
MAX_BURST, 4, maximum consecutive grants to one locked requester (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_we  in  2  bit i: 1 = write, 0 = read
req_lock  in  2  bit i: request to keep the grant after this transfer
req_addr  in  2*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
req_ready  out  2  bit i: request i accepted this cycle (one-hot or zero)
rsp_valid  out  2  bit i: read data for requester i valid (1-cycle pulse)
rsp_rdata  out  DATA_W  read data, qualified by rsp_valid
gnt_id  out  1  index of the last granted requester
locked  out  1  lock currently held
rf_wr_en  out  1  to register file wr_en
rf_w_addr  out  ADDR_W  to register file w_addr
rf_w_data  out  DATA_W  to register file w_data
rf_r_addr  out  ADDR_W  to register file r_addr
rf_r_data  in  DATA_W  from register file r_data (combinational read)

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_rdata=0, gnt_id=0, locked=0, prio=0, lock_owner=0, burst_cnt=0. Release is synchronous to clk.
- req_ready is combinational from req_valid plus state. A transfer happens when req_valid[i] && req_ready[i]. At most one bit of req_ready is set per cycle.
- Arbitration, unlocked: if only one requester is valid it is granted. If both are valid, the requester indexed by prio is granted.
- Arbitration, locked: only lock_owner may be granted. The other requester gets ready=0 even when valid.
  - If lock_owner has valid=0 in a locked cycle, the lock releases combinationally that cycle and unlocked arbitration applies, so no dead cycle.
- rf outputs for the granted request, in the same cycle:
  - Write: rf_wr_en=1, rf_w_addr=req_addr, rf_w_data=req_wdata. The file commits the write on that rising edge.
  - Read: rf_wr_en=0, rf_r_addr=req_addr. rf_r_data is registered into rsp_rdata on that edge, and rsp_valid[i]=1 in the following cycle only.
- No grant: rf_wr_en=0, all rf address and data outputs = 0. rsp_valid deasserts the cycle after a read response. rsp_rdata holds its last value.
- Latency: write, 0 cycles (committed at the accept edge). Read, 1 cycle (data on the cycle after accept). There is no response backpressure.
- Ordering: a read accepted in the cycle after a write to the same address returns the new data. Two operations never issue in the same cycle, so no hazard logic is needed.
- prio update on each grant to i:
  - Lock not retained: prio becomes ~i.
  - Lock retained: prio is unchanged.
- Lock/burst state machine with states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED: grant to i with req_lock[i]=1 and MAX_BURST>1. Sets lock_owner=i, burst_cnt=1.
  - LOCKED, grant to owner with req_lock=1 and burst_cnt+1 < MAX_BURST: stay LOCKED, burst_cnt increments.
  - LOCKED, grant to owner with req_lock=0, or burst_cnt+1 == MAX_BURST: go to UNLOCKED, burst_cnt=0, prio=~owner. This is a forced release.
  - LOCKED, owner not valid: go to UNLOCKED, burst_cnt=0, and the cycle is arbitrated as unlocked.
  - MAX_BURST=1: req_lock is ignored and the block behaves as pure round-robin.
- gnt_id updates on every grant. locked mirrors the state register.
- Reset mid-burst or mid-read: state clears immediately, a pending rsp_valid is dropped, and rf_wr_en goes to 0 while rst_n is low.

Test Plan:
- Single write then read: requester 0 writes addr 2 = 110. Next cycle it reads addr 2 -> req_ready[0]=1 both cycles, rf_wr_en=1 then 0, rsp_valid[0]=1 one cycle later with rsp_rdata=110.
- Round-robin contention: both requesters hold valid reads of addr 0 and 1 for 4 cycles -> grants alternate 0,1,0,1. rsp_valid pulses alternate, with data 100 and 101 (preloaded).
- Lock burst, MAX_BURST=4: requester 1 holds lock, valid writes of 120 to addr 3, while requester 0 is valid -> 4 grants to 1, then a forced release and a grant to 0. locked=1 for exactly the first 3 accept cycles after lock entry.
- Lock drop: owner deasserts valid while locked and requester 0 is valid -> requester 0 is granted that same cycle, and locked=0 next cycle.
- Async reset mid-read: assert rst_n=0 between read accept and the response edge -> rsp_valid stays 0, locked=0, prio=0, rf_wr_en=0 immediately.
- Idle: no valid for 5 cycles -> req_ready=0, rf_wr_en=0, rf addresses and data 0, rsp_valid=0.
